// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit processor front end.
package cpu_pkg;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int OP_W   = OP_MSB - OP_LSB + 1;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched word (plus its address) while the IR is stalled.
module fetch_skid_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              unload,
  input  logic              flush,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
      addr <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
      addr <= load_addr;
    end else if (unload) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, program-memory req/ack, IR with one-entry skid, redirect/squash.
module fetch_unit #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        jmp_loc,
  input  logic                     pc_mux_sel,
  input  logic                     stall,
  output logic                     pm_req,
  output logic [ADDR_W-1:0]        pm_addr,
  input  logic                     pm_ack,
  input  logic [INSTR_W-1:0]       pm_rdata,
  output logic [INSTR_W-1:0]       instr,
  output logic                     instr_valid,
  output logic [ADDR_W-1:0]        current_address,
  output logic [cpu_pkg::OP_W-1:0] op,
  output logic [ADDR_W-1:0]        jmp_address_pm
);
  import cpu_pkg::*;

  fetch_state_e        state, state_nxt;
  logic [ADDR_W-1:0]   pc, sq_addr;
  logic                pend;
  logic                redirect, ir_free, accept;
  logic                skid_full, skid_load, skid_unload;
  logic [INSTR_W-1:0]  skid_data;
  logic [ADDR_W-1:0]   skid_addr;

  assign redirect = pc_mux_sel & ~stall;
  assign ir_free  = ~instr_valid | ~stall;

  // A held request (pend) must stay up regardless of skid or redirect.
  always_comb begin
    pm_req  = 1'b0;
    pm_addr = pc;
    case (state)
      ST_FETCH:  pm_req = pend | (~skid_full & ~redirect);
      ST_SQUASH: begin
        pm_req  = 1'b1;
        pm_addr = sq_addr;
      end
      default:   pm_req = 1'b0;
    endcase
  end

  assign accept      = pm_req & pm_ack & (state == ST_FETCH) & ~redirect;
  assign skid_load   = accept & ~ir_free;
  assign skid_unload = ir_free & skid_full & ~redirect;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_FETCH;
      ST_FETCH:  if (redirect & pm_req & ~pm_ack) state_nxt = ST_SQUASH;
      ST_SQUASH: if (pm_ack) state_nxt = ST_FETCH;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      sq_addr <= RESET_PC;
      pend    <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pm_req & ~pm_ack;
      // Tracks pc until the squash starts, then freezes the stale address.
      if (state != ST_SQUASH) sq_addr <= pc;
      if (redirect)    pc <= jmp_loc;
      else if (accept) pc <= pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr           <= '0;
      instr_valid     <= 1'b0;
      current_address <= '0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (ir_free) begin
      if (skid_full) begin
        instr           <= skid_data;
        current_address <= skid_addr;
        instr_valid     <= 1'b1;
      end else if (accept) begin
        instr           <= pm_rdata;
        current_address <= pm_addr;
        instr_valid     <= 1'b1;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

  fetch_skid_buf #(.DATA_W(INSTR_W), .ADDR_W(ADDR_W)) u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .load      (skid_load),
    .load_data (pm_rdata),
    .load_addr (pm_addr),
    .unload    (skid_unload),
    .flush     (redirect),
    .full      (skid_full),
    .data      (skid_data),
    .addr      (skid_addr)
  );

  assign op             = instr[OP_MSB:OP_LSB];
  assign jmp_address_pm = instr[ADDR_W-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus randomized stall/redirect/latency traffic against a program-order model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] jmp_loc;
  logic        pc_mux_sel, stall;
  logic        pm_req, pm_ack;
  logic [15:0] pm_addr;
  logic [31:0] pm_rdata, instr;
  logic        instr_valid;
  logic [15:0] current_address, jmp_address_pm;
  logic [5:0]  op;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel), .stall(stall),
    .pm_req(pm_req), .pm_addr(pm_addr), .pm_ack(pm_ack), .pm_rdata(pm_rdata),
    .instr(instr), .instr_valid(instr_valid), .current_address(current_address),
    .op(op), .jmp_address_pm(jmp_address_pm)
  );

  int checks = 0, errors = 0;
  // memory model: wait cycles before ack for the current request
  int mcnt = 0, mlat = 0, lat_fix = 0;
  bit lat_rand = 1'b0;
  // program-order model
  bit mon_en = 1'b0;
  logic [15:0] exp_next;
  int gap = 0;
  logic        prev_req, prev_ack, prev_stall, prev_valid;
  logic [15:0] prev_addr, prev_cur;
  logic [31:0] prev_instr;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hA5C3, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_prev();
    prev_req = 0; prev_ack = 0; prev_stall = 0; prev_valid = 0;
    prev_addr = 0; prev_cur = 0; prev_instr = 0;
  endtask

  // Called just after a falling edge with inputs already set for this cycle.
  task automatic settle();
    logic [31:0] w;
    #1;
    pm_ack   = pm_req && (mcnt >= mlat);
    pm_rdata = pm_ack ? mem_word(pm_addr) : $urandom;
    #1;
    if (mon_en) begin
      if (prev_req && !prev_ack) begin
        chk("hs_req", 32'(pm_req), 32'h1);
        chk("hs_addr", 32'(pm_addr), 32'(prev_addr));
      end
      if (prev_stall && prev_valid) begin
        chk("hold_vld", 32'(instr_valid), 32'h1);
        chk("hold_addr", 32'(current_address), 32'(prev_cur));
        chk("hold_ir", instr, prev_instr);
      end
      if (instr_valid) begin
        w = mem_word(current_address);
        chk("ir_data", instr, w);
        chk("op", 32'(op), 32'(w[31:26]));
        chk("jmpf", 32'(jmp_address_pm), 32'(w[15:0]));
      end
      if (!stall) begin
        if (instr_valid) begin
          chk("order", 32'(current_address), 32'(exp_next));
          exp_next = exp_next + 16'd1;
          gap = 0;
        end
        if (pc_mux_sel) begin
          exp_next = jmp_loc;
          gap = 0;
        end
        if (!instr_valid && !pc_mux_sel) begin
          gap++;
          if (gap == 20) chk("live_gap", 32'(gap), 32'h0);
        end
      end
    end
  endtask

  task automatic adv();
    prev_req = pm_req; prev_ack = pm_ack; prev_addr = pm_addr; prev_stall = stall;
    prev_valid = instr_valid; prev_cur = current_address; prev_instr = instr;
    @(posedge clk);
    if (prev_req && prev_ack) begin
      mcnt = 0;
      mlat = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
    end else if (prev_req) begin
      mcnt++;
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  task automatic restart();
    reset = 1'b1; mcnt = 0; mlat = 0; lat_fix = 0; exp_next = 16'h0000;
    gap = 0; clear_prev(); mon_en = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout CHECKS %0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; stall = 1'b0; pc_mux_sel = 1'b0; jmp_loc = 16'h0;
    pm_ack = 1'b0; pm_rdata = 32'h0;
    clear_prev();
    @(negedge clk); @(negedge clk);
    settle();
    chk("rst_req", 32'(pm_req), 32'h0);
    chk("rst_addr", 32'(pm_addr), 32'h0);
    chk("rst_vld", 32'(instr_valid), 32'h0);
    chk("rst_ir", instr, 32'h0);
    chk("rst_cur", 32'(current_address), 32'h0);
    restart();

    settle(); chk("idle_req", 32'(pm_req), 32'h0); adv();
    settle(); chk("first_req", 32'(pm_req), 32'h1); chk("first_addr", 32'(pm_addr), 32'h0); adv();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin pc_mux_sel = 1'b1; jmp_loc = 16'h0040; end
      settle();
      chk("seq_vld", 32'(instr_valid), 32'h1);
      chk("seq_addr", 32'(current_address), 32'(i));
      adv();
    end
    pc_mux_sel = 1'b0;
    settle(); chk("bubble", 32'(instr_valid), 32'h0); chk("redir_addr", 32'(pm_addr), 32'h40); adv();

    // stall with 3-wait memory while 0x41 is in flight
    stall = 1'b1; lat_fix = 3; mlat = 3;
    settle(); chk("tgt_vld", 32'(instr_valid), 32'h1); chk("tgt_addr", 32'(current_address), 32'h40); adv();
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      settle(); chk("skid_noreq", 32'(pm_req), 32'h0); chk("skid_hold", 32'(current_address), 32'h40); adv();
    end
    stall = 1'b0;
    settle(); chk("rel_vld", 32'(instr_valid), 32'h1); chk("rel_held", 32'(current_address), 32'h40); adv();
    pc_mux_sel = 1'b1; jmp_loc = 16'h0010;
    settle(); chk("rel_skid", 32'(current_address), 32'h41); adv();
    pc_mux_sel = 1'b0;

    // redirect while 0x10 is outstanding
    settle(); chk("sq_issue_req", 32'(pm_req), 32'h1); chk("sq_issue", 32'(pm_addr), 32'h10); adv();
    pc_mux_sel = 1'b1; jmp_loc = 16'h0100;
    settle(); chk("sq_pend", 32'(pm_req), 32'h1); chk("sq_pend_addr", 32'(pm_addr), 32'h10); adv();
    pc_mux_sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("sq_req", 32'(pm_req), 32'h1);
      chk("sq_addr", 32'(pm_addr), 32'h10);
      chk("sq_vld", 32'(instr_valid), 32'h0);
      adv();
    end
    settle(); chk("sq_new_req", 32'(pm_req), 32'h1); chk("sq_new_addr", 32'(pm_addr), 32'h100);
    chk("sq_new_vld", 32'(instr_valid), 32'h0); adv();
    repeat (3) step();
    settle(); chk("sq_tgt_vld", 32'(instr_valid), 32'h1); chk("sq_tgt", 32'(current_address), 32'h100); adv();

    // enter SQUASH again, then pull reset without a clock edge
    pc_mux_sel = 1'b1; jmp_loc = 16'h0200; step(); pc_mux_sel = 1'b0;
    settle(); chk("sq2_req", 32'(pm_req), 32'h1); chk("sq2_addr", 32'(pm_addr), 32'h101);
    #1; reset = 1'b0; mon_en = 1'b0; pm_ack = 1'b0;
    #1;
    chk("ar_req", 32'(pm_req), 32'h0);
    chk("ar_addr", 32'(pm_addr), 32'h0);
    chk("ar_vld", 32'(instr_valid), 32'h0);
    chk("ar_ir", instr, 32'h0);
    chk("ar_cur", 32'(current_address), 32'h0);
    @(negedge clk); @(negedge clk);
    restart();
    settle(); chk("rs_idle", 32'(pm_req), 32'h0); adv();
    settle(); chk("rs_req", 32'(pm_req), 32'h1); chk("rs_addr", 32'(pm_addr), 32'h0); adv();
    settle(); chk("rs_vld", 32'(instr_valid), 32'h1); chk("rs_cur", 32'(current_address), 32'h0); adv();

    // pc wrap
    pc_mux_sel = 1'b1; jmp_loc = 16'hFFFE; step(); pc_mux_sel = 1'b0;
    step();
    settle(); chk("wrap_a", 32'(current_address), 32'hFFFE); adv();
    settle(); chk("wrap_b", 32'(current_address), 32'hFFFF); chk("wrap_pm", 32'(pm_addr), 32'h0); adv();
    settle(); chk("wrap_c", 32'(current_address), 32'h0); adv();

    // randomized traffic
    lat_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      stall      = ($urandom_range(0, 3) == 0);
      pc_mux_sel = ($urandom_range(0, 11) == 0);
      jmp_loc    = ($urandom_range(0, 2) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
